// File: rtl/mem_map_pkg.sv
// Shared definitions for the handshake memory controller: region map,
// request-size field encodings, FSM states and latency-counter width.
package mem_map_pkg;

    // Region select nibble, req_addr[31:28]
    localparam logic [3:0] REGION_ROM  = 4'h0;
    localparam logic [3:0] REGION_RAM  = 4'h1;
    localparam logic [3:0] REGION_KB   = 4'h2;
    localparam logic [3:0] REGION_DISP = 4'h3;

    // req_size bit positions
    localparam int SZ_HALF_BIT     = 0;
    localparam int SZ_WORD_BIT     = 1;
    localparam int SZ_UNSIGNED_BIT = 2;

    // Width of the wait-state counter (latencies 0..15)
    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_width_t;

    // Word wins over half: bit1 set means a full word regardless of bit0.
    function automatic acc_width_t size_width(input logic [2:0] size);
        if (size[SZ_WORD_BIT]) begin
            return ACC_WORD;
        end else if (size[SZ_HALF_BIT]) begin
            return ACC_HALF;
        end
        return ACC_BYTE;
    endfunction

    // Natural alignment check for the access width.
    function automatic logic is_misaligned(input logic [2:0] size,
                                           input logic [1:0] addr_lo);
        unique case (size_width(size))
            ACC_WORD: return (addr_lo != 2'b00);
            ACC_HALF: return addr_lo[0];
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic: load extraction with sign/zero extension, and store
// byte-enable generation with lane replication. Purely combinational.
module mem_lane_unit
    import mem_map_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_size,
    input  logic        i_full_word,
    input  logic [31:0] i_rdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata
);

    acc_width_t  w_width;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_signed;

    assign w_width  = size_width(i_size);
    assign w_signed = ~i_size[SZ_UNSIGNED_BIT];

    // Select the addressed lane of the device word and extend it to 32 bits
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_byte      = 8'h00;
        w_half      = 16'h0000;
        o_load_data = i_rdata;
        unique case (i_addr_lo)
            2'd0: w_byte = i_rdata[7:0];
            2'd1: w_byte = i_rdata[15:8];
            2'd2: w_byte = i_rdata[23:16];
            2'd3: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        if (!i_full_word) begin
            unique case (w_width)
                ACC_HALF: o_load_data = {{16{w_signed & w_half[15]}}, w_half};
                ACC_BYTE: o_load_data = {{24{w_signed & w_byte[7]}}, w_byte};
                default:  o_load_data = i_rdata;
            endcase
        end
    end

    // Build byte enables and replicate store data across every lane
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        unique case (w_width)
            ACC_BYTE: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            ACC_HALF: begin
                o_be    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_ctrl_hs.sv
// CPU-side memory controller with valid/ready request and response
// channels. One transaction is outstanding at a time; each device region
// has its own read latency. Misaligned, unmapped and wrong-direction
// accesses return a bus error without touching any device.
module mem_ctrl_hs
    import mem_map_pkg::*;
#(
    parameter int ROM_AW  = 12,
    parameter int RAM_AW  = 12,
    parameter int KB_AW   = 6,
    parameter int DISP_AW = 14,
    parameter int ROM_LAT = 1,
    parameter int RAM_LAT = 1,
    parameter int KB_LAT  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    // core request channel
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [31:0]         req_addr,
    input  logic [31:0]         req_wdata,
    input  logic [2:0]          req_size,
    // core response channel
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_err,
    // ROM
    output logic                rom_en,
    output logic [ROM_AW-1:0]   rom_addr,
    input  logic [31:0]         rom_rdata,
    // RAM
    output logic                ram_en,
    output logic [3:0]          ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [31:0]         ram_wdata,
    input  logic [31:0]         ram_rdata,
    // keyboard
    output logic                kb_rd,
    output logic [KB_AW-1:0]    kb_addr,
    input  logic [31:0]         kb_rdata,
    // display
    output logic                disp_we,
    output logic [3:0]          disp_be,
    output logic [DISP_AW-1:0]  disp_addr,
    output logic [31:0]         disp_wdata
);

    localparam logic [LAT_W-1:0] ROM_LAT_V = ROM_LAT[LAT_W-1:0];
    localparam logic [LAT_W-1:0] RAM_LAT_V = RAM_LAT[LAT_W-1:0];
    localparam logic [LAT_W-1:0] KB_LAT_V  = KB_LAT[LAT_W-1:0];

    state_t             r_state;
    state_t             w_state_next;

    // latched request
    logic               r_write;
    logic [2:0]         r_size;
    logic [3:0]         r_region;
    logic [27:0]        r_addr;
    logic [31:0]        r_wdata;

    logic [LAT_W-1:0]   r_cnt;
    logic [31:0]        r_rsp_rdata;
    logic               r_rsp_err;

    logic               w_req_err;
    logic               w_accept;
    logic               w_capture;
    logic               w_load_cnt;
    logic               w_issue;
    logic [LAT_W-1:0]   w_lat;
    logic [31:0]        w_raw_rdata;
    logic [31:0]        w_load_data;
    logic [3:0]         w_be;
    logic [31:0]        w_lane_wdata;
    logic               w_unused_addr;

    // Address bits above the widest device window are don't-care aliases.
    assign w_unused_addr = ^r_addr;

    // Classify the incoming request before it is accepted
    always_comb begin
        w_req_err = is_misaligned(req_size, req_addr[1:0]);
        unique case (req_addr[31:28])
            REGION_ROM:  if (req_write)  w_req_err = 1'b1;
            REGION_RAM:  ;
            REGION_KB:   if (req_write)  w_req_err = 1'b1;
            REGION_DISP: if (!req_write) w_req_err = 1'b1;
            default:     w_req_err = 1'b1;
        endcase
    end

    // Read latency and raw read data of the region being served
    always_comb begin
        w_lat       = '0;
        w_raw_rdata = 32'h0000_0000;
        unique case (r_region)
            REGION_ROM: begin w_lat = ROM_LAT_V; w_raw_rdata = rom_rdata; end
            REGION_RAM: begin w_lat = RAM_LAT_V; w_raw_rdata = ram_rdata; end
            REGION_KB:  begin w_lat = KB_LAT_V;  w_raw_rdata = kb_rdata;  end
            default:    ;
        endcase
    end

    mem_lane_unit u_lane (
        .i_addr_lo   (r_addr[1:0]),
        .i_size      (r_size),
        .i_full_word (r_region == REGION_KB),
        .i_rdata     (w_raw_rdata),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_be        (w_be),
        .o_wdata     (w_lane_wdata)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and datapath control strobes
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_load_cnt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = w_req_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_write) begin
                    w_state_next = ST_RESP;
                end else if (w_lat == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end else begin
                    w_load_cnt   = 1'b1;
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Latch the request, run the wait counter and hold the response
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: datapath registers are reset too, so rsp_rdata/rsp_err read 0 after an abort.
        if (!rst_n) begin
            r_write     <= 1'b0;
            r_size      <= 3'b000;
            r_region    <= 4'h0;
            r_addr      <= '0;
            r_wdata     <= 32'h0000_0000;
            r_cnt       <= '0;
            r_rsp_rdata <= 32'h0000_0000;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write     <= req_write;
                r_size      <= req_size;
                r_region    <= req_addr[31:28];
                r_addr      <= req_addr[27:0];
                r_wdata     <= req_wdata;
                r_rsp_err   <= w_req_err;
                r_rsp_rdata <= 32'h0000_0000;
            end
            if (w_load_cnt) begin
                r_cnt <= w_lat - 1'b1;
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_capture) begin
                r_rsp_rdata <= w_load_data;
            end
        end
    end

    assign w_issue   = (r_state == ST_ISSUE);
    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = (r_state == ST_RESP);
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // Device strobes exist only during ISSUE; errors never reach ISSUE.
    assign rom_en     = w_issue && (r_region == REGION_ROM);
    assign rom_addr   = r_addr[ROM_AW+1:2];

    assign ram_en     = w_issue && (r_region == REGION_RAM);
    assign ram_we     = (ram_en && r_write) ? w_be : 4'b0000;
    assign ram_addr   = r_addr[RAM_AW+1:2];
    assign ram_wdata  = w_lane_wdata;

    assign kb_rd      = w_issue && (r_region == REGION_KB);
    assign kb_addr    = r_addr[KB_AW+1:2];

    assign disp_we    = w_issue && (r_region == REGION_DISP);
    assign disp_be    = disp_we ? w_be : 4'b0000;
    assign disp_addr  = r_addr[DISP_AW+1:2];
    assign disp_wdata = w_lane_wdata;

endmodule
